// File: rtl/mcpu_pkg.sv
// Shared widths, FSM encoding and status codes for the MCPU run controller.
package mcpu_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 6;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [1:0] ST_LOAD    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_HALT    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/mcpu_halt_detect.sv
// Flags a halted core: the fetch address has stayed unchanged for HALT_CYCLES cycles.
module mcpu_halt_detect
    import mcpu_pkg::*;
#(
    parameter int HALT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    output logic              fire
);

    localparam int CNT_W = (HALT_CYCLES > 2) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FIRE_CNT = CNT_W'(HALT_CYCLES - 1);

    logic [ADDR_W-1:0] last_addr;
    logic [CNT_W-1:0]  same_cnt;
    logic              same;

    assign same = (addr == last_addr);
    assign fire = en && same && (same_cnt == FIRE_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr <= '0;
            same_cnt  <= '0;
        end else if (clr || !en) begin
            last_addr <= '0;
            same_cnt  <= '0;
        end else begin
            last_addr <= addr;
            if (!same)
                same_cnt <= '0;
            else if (same_cnt != '1)
                same_cnt <= same_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mcpu_memctl.sv
// MCPU run controller: shared 16x6 memory, host load/readback port, core sequencing,
// halt/timeout detection and run-cycle counting.
module mcpu_memctl
    import mcpu_pkg::*;
#(
    parameter int HALT_CYCLES = 4,
    parameter int CYC_W       = 12,
    parameter int TIMEOUT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [1:0]        status,
    output logic [CYC_W-1:0]  cyc_count
);

    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state, state_nxt;
    logic              timed_out;
    logic              running, halt_fire, to_fire;
    logic              core_wr, host_acc;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign running = (state == RUN);
    assign to_fire = TO_EN && running && (cyc_count == TO_LAST);

    mcpu_halt_detect #(.HALT_CYCLES(HALT_CYCLES)) u_halt (
        .clk  (clk),
        .rst  (rst),
        .en   (running),
        .clr  (!running),
        .addr (cpu_addr),
        .fire (halt_fire)
    );

    // stop outranks start in every state
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (!stop && start) state_nxt = RUN;
            RUN:     if (stop) state_nxt = LOAD;
                     else if (halt_fire || to_fire) state_nxt = HALT;
            HALT:    if (stop) state_nxt = LOAD;
                     else if (start) state_nxt = RUN;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            cpu_rst   <= 1'b0;
            timed_out <= 1'b0;
            cyc_count <= '0;
        end else begin
            state   <= state_nxt;
            cpu_rst <= (state_nxt == RUN);
            if (running && state_nxt == HALT)
                timed_out <= !halt_fire;
            // counter freezes on the edge that leaves RUN so it reports the last RUN cycle
            if (state_nxt == RUN) begin
                if (!running)
                    cyc_count <= '0;
                else if (cyc_count != '1)
                    cyc_count <= cyc_count + 1'b1;
            end
        end
    end

    always_comb begin
        case (state)
            RUN:     status = ST_RUN;
            HALT:    status = timed_out ? ST_TIMEOUT : ST_HALT;
            default: status = ST_LOAD;
        endcase
    end

    // the core owns any cycle in which it writes, so host writes wait for cpu_we high
    assign host_ready = !running || !host_wr || cpu_we;
    assign host_acc   = host_valid && host_ready;
    assign core_wr    = running && !cpu_we;
    assign cpu_rdata  = mem[cpu_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= '0;
        end else if (core_wr) begin
            mem[cpu_addr] <= cpu_wdata;
        end else if (host_acc && host_wr) begin
            mem[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            host_rsp_valid <= 1'b0;
            host_rdata     <= '0;
        end else begin
            host_rsp_valid <= host_acc;
            if (host_acc)
                host_rdata <= mem[host_addr];
        end
    end

endmodule

// File: tb/tb_mcpu_memctl.sv
// Directed bench for mcpu_memctl: the bench plays the core's bus by hand.
module tb_mcpu_memctl;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic       cpu_rst;
    logic [3:0] cpu_addr;
    logic [5:0] cpu_wdata;
    logic       cpu_we;
    logic [5:0] cpu_rdata;
    logic       host_valid, host_ready, host_wr;
    logic [3:0] host_addr;
    logic [5:0] host_wdata;
    logic       host_rsp_valid;
    logic [5:0] host_rdata;
    logic [1:0] status;
    logic [11:0] cyc_count;

    int n_chk = 0;
    int n_err = 0;

    // core trace for "ADD 15; STA 14; JCC 2": addr, we, wdata, expected rdata
    int t_addr [9] = '{0, 15, 1, 14, 2, 2, 2, 2, 2};
    int t_we   [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int t_rd   [9] = '{'h1F, 'h03, 'h2E, 'h00, 'h32, 'h32, 'h32, 'h32, 'h32};

    always #5 clk = ~clk;

    mcpu_memctl #(.HALT_CYCLES(4), .CYC_W(12), .TIMEOUT(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .cpu_rst        (cpu_rst),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_rdata      (cpu_rdata),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .host_wr        (host_wr),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rdata     (host_rdata),
        .status         (status),
        .cyc_count      (cyc_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_op(input logic wr, input logic [3:0] a, input logic [5:0] d);
        host_valid = 1'b1;
        host_wr    = wr;
        host_addr  = a;
        host_wdata = d;
        step();
        host_valid = 1'b0;
        host_wr    = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [3:0] a, input logic [5:0] exp);
        host_op(1'b0, a, 6'd0);
        check({tag, "_vld"}, 32'(host_rsp_valid), 1);
        check(tag, 32'(host_rdata), 32'(exp));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cpu_addr = 4'd0; cpu_wdata = 6'd0; cpu_we = 1'b1;
        host_valid = 1'b0; host_wr = 1'b0; host_addr = 4'd0; host_wdata = 6'd0;
        #12;
        check("rst_cpu_rst", 32'(cpu_rst), 0);
        check("rst_status", 32'(status), 0);
        check("rst_cyc", 32'(cyc_count), 0);
        check("rst_rsp_vld", 32'(host_rsp_valid), 0);
        check("rst_rdata", 32'(host_rdata), 0);
        step();
        rst = 1'b1;

        // load: first write returns the old (zero) contents
        host_op(1'b1, 4'd0, 6'h30);
        check("ld_wr_rsp_vld", 32'(host_rsp_valid), 1);
        check("ld_wr_rsp_old", 32'(host_rdata), 0);
        host_op(1'b1, 4'd1, 6'h05);
        host_read("ld_rd1", 4'd1, 6'h05);
        check("ld_cpu_rst", 32'(cpu_rst), 0);
        check("ld_status", 32'(status), 0);

        // program ADD 15; STA 14; JCC 2 with mem[15]=3
        host_op(1'b1, 4'd0, 6'h1F);
        host_op(1'b1, 4'd1, 6'h2E);
        host_op(1'b1, 4'd2, 6'h32);
        host_op(1'b1, 4'd15, 6'h03);
        host_read("ld_rd0", 4'd0, 6'h1F);
        check("ld_status2", 32'(status), 0);

        pulse_start();
        check("run_cpu_rst", 32'(cpu_rst), 1);
        check("run_cyc0", 32'(cyc_count), 0);
        for (int k = 0; k < 9; k++) begin
            cpu_addr  = 4'(t_addr[k]);
            cpu_we    = t_we[k][0];
            cpu_wdata = 6'h03;
            #1;
            check($sformatf("run_status_c%0d", k), 32'(status), 1);
            check($sformatf("run_rdata_c%0d", k), 32'(cpu_rdata), 32'(t_rd[k]));
            step();
        end
        cpu_we = 1'b1;
        check("halt_status", 32'(status), 2);
        check("halt_cpu_rst", 32'(cpu_rst), 0);
        check("halt_cyc", 32'(cyc_count), 8);
        host_read("halt_rd14", 4'd14, 6'h03);

        // restart from HALT, then a host write colliding with a core write
        pulse_start();
        check("rs_status", 32'(status), 1);
        check("rs_cyc", 32'(cyc_count), 0);
        check("rs_cpu_rst", 32'(cpu_rst), 1);
        cpu_addr = 4'd0;
        #1;
        check("rs_fetch0", 32'(cpu_rdata), 'h1F);
        step();
        cpu_addr = 4'd5; cpu_we = 1'b0; cpu_wdata = 6'h11;
        host_valid = 1'b1; host_wr = 1'b1; host_addr = 4'd14; host_wdata = 6'h2A;
        #1;
        check("col_ready0", 32'(host_ready), 0);
        step();
        check("col_rsp_vld0", 32'(host_rsp_valid), 0);
        cpu_addr = 4'd6; cpu_we = 1'b1;
        #1;
        check("col_ready1", 32'(host_ready), 1);
        step();
        host_valid = 1'b0; host_wr = 1'b0;
        check("col_rsp_vld1", 32'(host_rsp_valid), 1);
        check("col_rsp_old", 32'(host_rdata), 'h03);
        cpu_addr = 4'd7;
        host_read("col_rd14", 4'd14, 6'h2A);
        cpu_addr = 4'd8;
        host_read("col_rd5", 4'd5, 6'h11);

        // start and stop together: stop wins
        cpu_addr = 4'd9;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_status", 32'(status), 0);
        check("ss_cpu_rst", 32'(cpu_rst), 0);
        check("ss_cyc_hold", 32'(cyc_count), 5);
        cpu_addr = 4'd7; cpu_we = 1'b0; cpu_wdata = 6'h3F;
        step();
        cpu_we = 1'b1;
        host_read("ss_rd7", 4'd7, 6'h00);

        // timeout at cyc_count 19 without a self-loop
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            cpu_addr = 4'(k % 4);
            #1;
            check($sformatf("to_status_c%0d", k), 32'(status), 1);
            check($sformatf("to_cyc_c%0d", k), 32'(cyc_count), 32'(k));
            step();
        end
        check("to_status", 32'(status), 3);
        check("to_cyc", 32'(cyc_count), 19);
        step();
        step();
        check("to_status_hold", 32'(status), 3);
        check("to_cyc_hold", 32'(cyc_count), 19);

        // halt and timeout on the same cycle: self-loop status wins
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            cpu_addr = (k < 15) ? 4'(k % 4) : 4'd9;
            step();
        end
        check("both_status", 32'(status), 2);
        check("both_cyc", 32'(cyc_count), 19);

        // asynchronous reset in the middle of RUN
        pulse_start();
        cpu_addr = 4'd14;
        host_read("ar_rd14", 4'd14, 6'h2A);
        check("ar_cyc_pre", 32'(cyc_count), 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_cpu_rst", 32'(cpu_rst), 0);
        check("ar_status", 32'(status), 0);
        check("ar_cyc", 32'(cyc_count), 0);
        check("ar_rsp_vld", 32'(host_rsp_valid), 0);
        check("ar_rdata", 32'(host_rdata), 0);
        check("ar_cpu_rdata", 32'(cpu_rdata), 0);
        step();
        rst = 1'b1;
        for (int a = 0; a < 16; a++)
            host_read($sformatf("ar_mem%0d", a), 4'(a), 6'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mcpu_memctl.md
Name: mcpu_memctl

Overview:
- Run controller and program/data memory for the 6-bit MCPU core: 16 x 6-bit register memory shared between the core and a host load/readback port.
- Sequences the core: holds it in reset while the host loads a program, releases it to run, and detects a halt (jump-to-self) or a timeout.
- Reports run status and the number of cycles executed.
- Sits between the core's bus signals and the chip I/O; the integration wrapper provides demultiplexed core address and write data.

Parameters:
- HALT_CYCLES, 4, consecutive cycles with an unchanged core address that mean a halt. Legal range is 3 or more; one normal instruction repeats an address at most twice.
- CYC_W, 12, width of the cycle counter.
- TIMEOUT, 0, run-cycle limit before a forced halt. 0 disables the limit; otherwise 1 to 2^CYC_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin or restart the program.
- stop  in  1  one-cycle pulse: abort and return to load mode.
- cpu_rst  out  1  active-low synchronous reset to the core; registered.
- cpu_addr  in  4  core address (adreg).
- cpu_wdata  in  6  core write data (accumulator[5:0]).
- cpu_we  in  1  core write strobe, active-low (0 = write).
- cpu_rdata  out  6  memory read data to the core.
- host_valid  in  1  host command valid.
- host_ready  out  1  host command accepted this cycle.
- host_wr  in  1  1 = write, 0 = read.
- host_addr  in  4  host address.
- host_wdata  in  6  host write data.
- host_rsp_valid  out  1  response valid, registered.
- host_rdata  out  6  response data, registered.
- status  out  2  00 LOAD, 01 RUN, 10 HALT (self-loop), 11 HALT (timeout).
- cyc_count  out  CYC_W  cycles spent in RUN since the last start.

Behaviour:
- Reset (rst low, asynchronous), all of the following:
  - state = LOAD, cpu_rst = 0, status = 00.
  - cyc_count = 0, host_rsp_valid = 0, host_rdata = 0.
  - Memory cleared to 0.
  - Halt detector cleared.
- FSM states: LOAD, RUN, HALT. cpu_rst is 1 only in RUN.
  - LOAD: on start go to RUN; cyc_count and the halt detector clear on that edge.
  - RUN: on stop go to LOAD. Otherwise go to HALT when the halt detector fires or the timeout fires. If both fire in the same cycle, status = 10.
  - HALT: on start go to RUN (restart from pc 0); on stop go to LOAD.
  - start and stop in the same cycle: stop wins.
- cpu_rst is low for at least one clock before any RUN, so the core's synchronous reset always takes effect.
- Core reads: cpu_rdata = mem[cpu_addr], combinational in every state.
- Core writes: mem[cpu_addr] <= cpu_wdata on the clock edge when state = RUN and cpu_we = 0. Core writes are ignored in LOAD and HALT.
- Host handshake:
  - host_ready = 1 in LOAD and HALT.
  - In RUN, host_ready = 1 for reads always, and for writes only when cpu_we = 1. The core always wins a write cycle, so there are never two writers in one cycle.
  - A command is accepted when host_valid & host_ready.
  - One cycle after acceptance: host_rsp_valid = 1 and host_rdata = the contents of mem[host_addr] before that edge, for both reads and writes.
  - A host write takes effect on the acceptance edge.
  - Back-to-back commands are accepted every cycle.
  - A host write and a core read of the same address in the same cycle: the core sees the old value.
- Cycle counter:
  - In RUN, cyc_count increments every cycle and saturates at all-ones.
  - It holds its value in HALT and LOAD.
  - It clears on every transition into RUN.
- Timeout: when TIMEOUT != 0, the timeout fires in RUN on the cycle where cyc_count == TIMEOUT-1.
- Halt detector:
  - Registers last_addr and a same-count.
  - Each RUN cycle: if cpu_addr == last_addr, same-count increments (saturating); otherwise it resets to 0.
  - It fires when same-count reaches HALT_CYCLES-1 and the current address matches.
  - It is cleared outside RUN.
- Address wrap 15 -> 0 is an ordinary address change; no special case.

Decomposition:
- mcpu_pkg holds:
  - ADDR_W = 4 and DATA_W = 6.
  - The state encoding: LOAD = 2'd0, RUN = 2'd1, HALT = 2'd2.
  - The status codes: ST_LOAD, ST_RUN, ST_HALT, ST_TIMEOUT.
- One sub-module, mcpu_halt_detect.
  - Inputs: clk, rst, en (state == RUN), clr, addr.
  - Output: fire.
  - Parameter: HALT_CYCLES.

Test Plan:
1. Reset, then host writes mem[0]=0x30, mem[1]=0x05, mem[2..15]=0, then reads addr 1. Required: host_rdata = 0x05 one cycle after acceptance; cpu_rst = 0 and status = 00 throughout.
2. Program "ADD 15; STA 14; JCC 2" with mem[15]=0x03, then start. Required:
   - cpu_rst goes high the next cycle.
   - The core writes mem[14]=0x03 in RUN.
   - The self-loop leaves cpu_addr constant, and status = 10 exactly HALT_CYCLES cycles after the address first repeats.
   - cpu_rst returns low; host readback of addr 14 = 0x03.
3. TIMEOUT=20 with a program that loops without a self-jump. Required: status = 11 when cyc_count = 19, and cyc_count holds at 19 in HALT.
4. In RUN, issue a host write on a cycle with cpu_we = 0. Required: host_ready = 0, the command is held, it is accepted on the next cycle with cpu_we = 1, and the response carries the pre-write data.
5. Pulse start and stop in the same cycle during RUN. Required: next state LOAD, status = 00, core writes ignored afterwards. Then assert rst mid-RUN: all outputs go to reset values asynchronously and the memory reads back all 0.
6. In HALT, pulse start. Required: RUN, cyc_count = 0, the core restarts from address 0 (cpu_addr = 0 on the first fetch).
